// File: rtl/ai_unit_arbiter.sv
// Round-robin arbiter sharing one multi-cycle AI execution unit between two
// requesters, with start/done sequencing, a timeout watchdog and a tagged response channel.
module ai_unit_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_opcode,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [4:0]  req0_rd,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_opcode,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [4:0]  req1_rd,
    output logic        unit_start,
    output logic [2:0]  unit_opcode,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    input  logic        unit_done,
    input  logic [31:0] unit_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_port,
    output logic [4:0]  rsp_rd,
    output logic [31:0] rsp_result,
    output logic        rsp_error,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    logic             grant;
    logic             accept;
    logic             timeout;
    logic [CNT_W-1:0] wd_cnt;

    // Contested cycles go to the port that did not win last; otherwise the lone requester.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid)
            grant = ~last_grant;
        else if (req1_valid)
            grant = 1'b1;
    end

    assign timeout = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Handshake outputs are gated by reset so they drop the moment reset asserts.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        unit_start = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                accept     = reset && (req0_valid || req1_valid);
                req0_ready = accept && !grant;
                req1_ready = accept && grant;
                if (accept)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                busy       = reset;
                unit_start = reset;
                state_nxt  = WAIT;
            end
            WAIT: begin
                busy = reset;
                if (unit_done || timeout)
                    state_nxt = RESP;
            end
            RESP: begin
                busy      = reset;
                rsp_valid = reset;
                if (rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant  <= 1'b1;
            unit_opcode <= '0;
            unit_a      <= '0;
            unit_b      <= '0;
            rsp_port    <= 1'b0;
            rsp_rd      <= '0;
            rsp_result  <= '0;
            rsp_error   <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        last_grant  <= grant;
                        rsp_port    <= grant;
                        unit_opcode <= grant ? req1_opcode : req0_opcode;
                        unit_a      <= grant ? req1_a      : req0_a;
                        unit_b      <= grant ? req1_b      : req0_b;
                        rsp_rd      <= grant ? req1_rd     : req0_rd;
                    end
                end
                ISSUE: wd_cnt <= '0;
                WAIT: begin
                    // A completion in the timeout cycle takes priority over the error.
                    if (unit_done) begin
                        rsp_result <= unit_result;
                        rsp_error  <= 1'b0;
                    end else if (timeout) begin
                        rsp_result <= '0;
                        rsp_error  <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ai_unit_arbiter.sv
// Directed self-checking bench for ai_unit_arbiter with an 8-cycle watchdog.
module tb_ai_unit_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_opcode, req1_opcode;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]  req0_rd, req1_rd;
    logic        unit_start;
    logic [2:0]  unit_opcode;
    logic [31:0] unit_a, unit_b;
    logic        unit_done;
    logic [31:0] unit_result;
    logic        rsp_valid, rsp_ready, rsp_port, rsp_error, busy;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_result;

    int unsigned tests  = 0;
    int unsigned failed = 0;

    ai_unit_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_a(req0_a), .req0_b(req0_b), .req0_rd(req0_rd),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_a(req1_a), .req1_b(req1_b), .req1_rd(req1_rd),
        .unit_start(unit_start), .unit_opcode(unit_opcode), .unit_a(unit_a), .unit_b(unit_b),
        .unit_done(unit_done), .unit_result(unit_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_port(rsp_port), .rsp_rd(rsp_rd),
        .rsp_result(rsp_result), .rsp_error(rsp_error), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here, checks follow a #1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] rd0, rd1;
        logic       exp_port;

        reset = 1'b0;
        req0_valid = 1'b1; req0_opcode = '0; req0_a = '0; req0_b = '0; req0_rd = '0;
        req1_valid = 1'b1; req1_opcode = '0; req1_a = '0; req1_b = '0; req1_rd = '0;
        unit_done = 1'b0; unit_result = '0; rsp_ready = 1'b0;

        // Reset state, even with requests pending
        #2;
        check("rst_ready0", {31'b0, req0_ready}, 32'd0);
        check("rst_ready1", {31'b0, req1_ready}, 32'd0);
        check("rst_busy",   {31'b0, busy},       32'd0);
        check("rst_rspv",   {31'b0, rsp_valid},  32'd0);
        check("rst_start",  {31'b0, unit_start}, 32'd0);
        check("rst_rd",     {27'b0, rsp_rd},     32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        reset = 1'b1;

        // Single port-0 op
        req0_valid = 1'b1; req0_opcode = 3'b001; req0_a = 32'd5; req0_b = 32'd7; req0_rd = 5'd9;
        #1;
        check("t1_ready0", {31'b0, req0_ready}, 32'd1);
        check("t1_ready1", {31'b0, req1_ready}, 32'd0);
        check("t1_busy_idle", {31'b0, busy}, 32'd0);
        tick();                                   // ISSUE
        req0_valid = 1'b0;
        #1;
        check("t1_start",  {31'b0, unit_start}, 32'd1);
        check("t1_opcode", {29'b0, unit_opcode}, 32'd1);
        check("t1_a",      unit_a, 32'd5);
        check("t1_b",      unit_b, 32'd7);
        check("t1_busy",   {31'b0, busy}, 32'd1);
        check("t1_ready0_issue", {31'b0, req0_ready}, 32'd0);
        tick();                                   // WAIT cnt0
        #1;
        check("t1_start_off", {31'b0, unit_start}, 32'd0);
        tick();                                   // WAIT cnt1: done two cycles after start
        unit_done = 1'b1; unit_result = 32'd35;
        tick();                                   // RESP
        unit_done = 1'b0;
        #1;
        check("t1_rspv",   {31'b0, rsp_valid}, 32'd1);
        check("t1_port",   {31'b0, rsp_port},  32'd0);
        check("t1_rd",     {27'b0, rsp_rd},    32'd9);
        check("t1_result", rsp_result,         32'd35);
        check("t1_error",  {31'b0, rsp_error}, 32'd0);
        check("t1_busy_resp", {31'b0, busy},   32'd1);
        rsp_ready = 1'b1;
        tick();                                   // IDLE
        rsp_ready = 1'b0;
        #1;
        check("t1_busy_done", {31'b0, busy},     32'd0);
        check("t1_rspv_done", {31'b0, rsp_valid}, 32'd0);

        // Reset pulse between operations clears latched tag and restores port-0 priority
        reset = 1'b0;
        #1;
        check("rst2_rd", {27'b0, rsp_rd}, 32'd0);
        #1;
        reset = 1'b1;

        // Fairness: both ports always valid, unit completes 3 cycles after start
        rd0 = 5'd10; rd1 = 5'd20;
        req0_valid = 1'b1; req0_rd = rd0; req0_a = 32'd10; req0_b = 32'd1; req0_opcode = 3'd2;
        req1_valid = 1'b1; req1_rd = rd1; req1_a = 32'd20; req1_b = 32'd2; req1_opcode = 3'd3;
        for (int unsigned i = 0; i < 4; i++) begin
            exp_port = (i % 2 == 1);
            #1;
            check("f_ready0", {31'b0, req0_ready}, {31'b0, ~exp_port});
            check("f_ready1", {31'b0, req1_ready}, {31'b0, exp_port});
            tick();                               // ISSUE
            #1;
            check("f_unit_a", unit_a, exp_port ? {27'b0, rd1} : {27'b0, rd0});
            check("f_ready_issue", {30'b0, req0_ready, req1_ready}, 32'd0);
            if (exp_port) begin
                rd1 = rd1 + 5'd1; req1_rd = rd1; req1_a = {27'b0, rd1};
            end else begin
                rd0 = rd0 + 5'd1; req0_rd = rd0; req0_a = {27'b0, rd0};
            end
            tick();                               // WAIT cnt0
            tick();                               // WAIT cnt1
            tick();                               // WAIT cnt2
            unit_done = 1'b1; unit_result = 32'd100 + i;
            tick();                               // RESP
            unit_done = 1'b0;
            #1;
            check("f_rspv",   {31'b0, rsp_valid}, 32'd1);
            check("f_port",   {31'b0, rsp_port},  {31'b0, exp_port});
            check("f_rd",     {27'b0, rsp_rd},    exp_port ? {27'b0, rd1 - 5'd1} : {27'b0, rd0 - 5'd1});
            check("f_result", rsp_result,         32'd100 + i);
            check("f_ready_resp", {30'b0, req0_ready, req1_ready}, 32'd0);
            rsp_ready = 1'b1;
            #1;
            check("f_ready_hs", {30'b0, req0_ready, req1_ready}, 32'd0);
            tick();                               // IDLE
            rsp_ready = 1'b0;
        end

        // Timeout: port 0 alone, unit never answers
        req1_valid = 1'b0;
        req0_rd = 5'd3; req0_a = 32'd33;
        #1;
        check("to_ready0", {31'b0, req0_ready}, 32'd1);
        tick();                                   // ISSUE
        req0_valid = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            tick();                               // WAIT cnt i
            #1;
            check("to_wait_rspv", {31'b0, rsp_valid}, 32'd0);
            check("to_wait_busy", {31'b0, busy}, 32'd1);
        end
        tick();                                   // RESP
        #1;
        check("to_rspv",   {31'b0, rsp_valid}, 32'd1);
        check("to_error",  {31'b0, rsp_error}, 32'd1);
        check("to_result", rsp_result, 32'd0);

        // Backpressure with port 1 waiting; spurious done in RESP
        req1_valid = 1'b1; req1_rd = 5'd17; req1_a = 32'd77; req1_opcode = 3'd5;
        for (int unsigned i = 0; i < 5; i++) begin
            if (i == 2) begin
                unit_done = 1'b1; unit_result = 32'hDEAD;
            end else begin
                unit_done = 1'b0;
            end
            #1;
            check("bp_rspv",   {31'b0, rsp_valid}, 32'd1);
            check("bp_rd",     {27'b0, rsp_rd},    32'd3);
            check("bp_port",   {31'b0, rsp_port},  32'd0);
            check("bp_error",  {31'b0, rsp_error}, 32'd1);
            check("bp_result", rsp_result,         32'd0);
            check("bp_ready1", {31'b0, req1_ready}, 32'd0);
            tick();
        end
        unit_done = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check("bp_hs_ready1", {31'b0, req1_ready}, 32'd0);
        tick();                                   // IDLE
        rsp_ready = 1'b0;
        #1;
        check("bp_idle_ready1", {31'b0, req1_ready}, 32'd1);
        check("bp_idle_busy",   {31'b0, busy},       32'd0);
        tick();                                   // ISSUE for port 1
        req1_valid = 1'b0;
        #1;
        check("bp_unit_a", unit_a, 32'd77);

        // Reset mid-WAIT with both ports requesting
        tick();                                   // WAIT cnt0
        tick();                                   // WAIT cnt1
        req0_valid = 1'b1; req0_rd = 5'd4; req0_a = 32'd44;
        req1_valid = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        check("mr_busy",   {31'b0, busy},       32'd0);
        check("mr_start",  {31'b0, unit_start}, 32'd0);
        check("mr_rspv",   {31'b0, rsp_valid},  32'd0);
        check("mr_ready",  {30'b0, req0_ready, req1_ready}, 32'd0);
        check("mr_unit_a", unit_a, 32'd0);
        tick();
        reset = 1'b1;
        #1;
        check("mr_grant0", {31'b0, req0_ready}, 32'd1);
        check("mr_grant1", {31'b0, req1_ready}, 32'd0);

        // Done arriving in the exact timeout cycle
        tick();                                   // ISSUE
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int unsigned i = 0; i < 7; i++) tick();   // WAIT cnt0..cnt6
        tick();                                   // WAIT cnt7
        unit_done = 1'b1; unit_result = 32'h1234;
        tick();                                   // RESP
        unit_done = 1'b0;
        #1;
        check("ct_rspv",   {31'b0, rsp_valid}, 32'd1);
        check("ct_error",  {31'b0, rsp_error}, 32'd0);
        check("ct_result", rsp_result,         32'h1234);
        check("ct_rd",     {27'b0, rsp_rd},    32'd4);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        check("ct_idle", {31'b0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/ai_unit_arbiter.md
Name: ai_unit_arbiter

Overview:
- Shares one multi-cycle AI execution unit (matrix multiplier and its controller) between two requesters.
  - Port 0: the EX-stage AI issue path.
  - Port 1: a secondary requester, e.g. a debug or DMA engine.
- Arbitrates round-robin and sequences the unit's start/done handshake.
- Guards each operation with a timeout watchdog.
- Returns the result, tagged with requester and destination register, over a valid/ready response channel that feeds writeback and stall logic.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles spent in WAIT before the operation is aborted with an error; legal range 2..65535.
- CNT_W, 16: width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0_valid  in  1  port 0 has an operation.
- req0_ready  out  1  port 0 operation accepted this cycle.
- req0_opcode  in  3  AI opcode.
- req0_a  in  32  operand A.
- req0_b  in  32  operand B.
- req0_rd  in  5  destination register tag.
- req1_valid, req1_ready, req1_opcode, req1_a, req1_b, req1_rd: same widths and meaning as port 0, for port 1.
- unit_start  out  1  one-cycle start pulse to the shared unit.
- unit_opcode  out  3  latched opcode.
- unit_a  out  32  latched operand A.
- unit_b  out  32  latched operand B.
- unit_done  in  1  unit completion pulse.
- unit_result  in  32  unit result; valid when unit_done=1.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_port  out  1  requester index (0/1).
- rsp_rd  out  5  tag of the completed operation.
- rsp_result  out  32  result; 0 on error.
- rsp_error  out  1  operation timed out.
- busy  out  1  high in every state except IDLE; drives the pipeline stall.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Reset values (reset=0, asynchronous):
  - state=IDLE; last_grant=1, so port 0 wins the first contest.
  - All outputs and latched operand/tag registers are 0.
  - Watchdog counter is 0.
- IDLE arbitration (combinational):
  - Only one valid: that port is granted.
  - Both valid: grant the port != last_grant.
  - reqN_ready = (state==IDLE) && grant==N. At most one ready is high in any cycle; no ready outside IDLE.
  - On acceptance: latch opcode, a, b, rd and port; set last_grant=N; go to ISSUE.
- ISSUE:
  - unit_start=1 for exactly this one cycle; unit_opcode/a/b hold the latched values from ISSUE until the next acceptance.
  - Clear the watchdog counter; go to WAIT.
  - unit_done is ignored in this cycle.
- WAIT:
  - unit_done=1: capture unit_result into rsp_result, rsp_error=0, go to RESP.
  - Otherwise increment the counter. When counter==TIMEOUT_CYCLES-1 and unit_done=0: rsp_result=0, rsp_error=1, go to RESP.
  - unit_done in the same cycle as the timeout condition: done wins, no error.
- RESP:
  - rsp_valid=1; rsp_port, rsp_rd, rsp_result and rsp_error are stable until the handshake.
  - rsp_valid && rsp_ready: go to IDLE. rsp_valid is 0 outside RESP.
  - New requests are not accepted in the handshake cycle; earliest next acceptance is the following cycle.
- Latency: accept at cycle T, start at T+1, done earliest at T+2, rsp_valid at T+3.
- unit_done in IDLE or RESP is spurious: ignored, with no state change.
- Requesters must hold valid and operands stable until ready. Dropping valid before ready is legal and simply forfeits the grant.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. Any in-flight result is discarded. The shared unit is reset by the same signal.
- Fairness: with both ports continuously valid, grants strictly alternate 0,1,0,1…

Test Plan:
- Single port-0 op: req0_valid=1, opcode=3'b001, a=5, b=7, rd=9; unit_done with result=35 two cycles after start.
  - Required: req0_ready for one cycle, unit_start one cycle later, then rsp_valid with port=0, rd=9, result=35, error=0.
  - busy high from ISSUE until the handshake.
- Both ports continuously valid over 4 ops, unit completing in 3 cycles each:
  - Grant order 0,1,0,1; never two readies in one cycle; rsp_rd matches each accepted tag.
- Timeout: TIMEOUT_CYCLES=8, unit_done held 0:
  - rsp_valid with error=1, result=0, exactly 8 WAIT cycles after ISSUE; next request accepted after rsp_ready.
- Backpressure and spurious done:
  - Hold rsp_ready=0 for 5 cycles: rsp fields stable, no new ready, req1 kept waiting.
  - Pulse unit_done while in RESP: no effect. Release rsp_ready: IDLE, then req1 granted next cycle.
- Reset mid-WAIT:
  - Drive reset=0 asynchronously: busy, unit_start, rsp_valid and both readies go to 0 immediately.
  - After release, the first contest with both ports valid grants port 0.
- Done-equals-timeout corner: unit_done asserted in the exact cycle counter==TIMEOUT_CYCLES-1.
  - Required: rsp_error=0 and result captured.
